// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int LEN_MAX  = 8;
  localparam int NPAT_MAX = 8;
  localparam int IDX_W    = 3;

  // Counts up to the all-ones value of a w-bit counter and sticks there.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = 32'hFFFF_FFFF >> (32 - w);
    return (v == top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Stream, configuration and status bundle of the sequence detector.
interface seq_detect_param_if
  import seq_det_pkg::*;
#(
  parameter int LEN   = 3,
  parameter int NPAT  = 2,
  parameter int CNT_W = 8
);

  logic                  en;
  logic                  s;
  logic                  overlap;
  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_idx;
  logic [LEN-1:0]        cfg_pat;
  logic                  cnt_clr;
  logic [NPAT-1:0]       y;
  logic [NPAT*CNT_W-1:0] cnt;
  logic                  armed;

  modport master (
    output en, s, overlap, cfg_we, cfg_idx, cfg_pat, cnt_clr,
    input  y, cnt, armed
  );

  modport slave (
    input  en, s, overlap, cfg_we, cfg_idx, cfg_pat, cnt_clr,
    output y, cnt, armed
  );

endinterface

// File: rtl/seq_det_chan.sv
// One pattern slot: pattern register, comparator, registered match pulse and
// saturating match counter. Match is combinational; y and cnt update on the same edge.
module seq_det_chan
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 3,
  parameter int             CNT_W   = 8,
  parameter logic [LEN-1:0] RST_VAL = '0
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             pat_we,
  input  logic [LEN-1:0]   pat_in,
  input  logic             cmp_en,
  input  logic [LEN-1:0]   nxt,
  input  logic             cnt_clr,
  output logic             match,
  output logic             y,
  output logic [CNT_W-1:0] cnt
);

  logic [LEN-1:0] pat;

  assign match = cmp_en && (nxt == pat);

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      pat <= RST_VAL;
      y   <= 1'b0;
      cnt <= '0;
    end else begin
      if (pat_we) begin
        pat <= pat_in;
      end
      y <= match;
      // Clear beats a coincident match; the pulse on y is still delivered.
      if (cnt_clr) begin
        cnt <= '0;
      end else if (match) begin
        cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial detector for NPAT programmable LEN-bit patterns; y pulses one cycle after
// the completing bit. No backpressure: one bit per cycle whenever en is high.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                  LEN     = 3,
  parameter int                  NPAT    = 2,
  parameter int                  CNT_W   = 8,
  parameter logic [NPAT*LEN-1:0] RST_PAT = {3'b100, 3'b011}
) (
  input logic               ck,
  input logic               rs,
  seq_detect_param_if.slave bus
);

  localparam int FILL_W = $clog2(LEN + 1);

  // The oldest bit drops out on the next shift, so only LEN-1 bits are kept.
  logic [LEN-2:0]        hist;
  logic [LEN-2:0]        hist_d;
  logic [FILL_W-1:0]     fill;
  logic [FILL_W-1:0]     fill_d;
  logic [FILL_W-1:0]     fill_inc;
  logic [LEN-1:0]        nxt;
  logic                  accept;
  logic                  cfg_hit;
  logic                  cmp_en;
  logic                  armed_q;
  logic [NPAT-1:0]       match;
  logic [NPAT-1:0]       y_w;
  logic [NPAT*CNT_W-1:0] cnt_w;

  assign accept   = bus.en && !bus.cfg_we;
  assign cfg_hit  = bus.cfg_we && (32'(bus.cfg_idx) < 32'(NPAT));
  assign nxt      = {hist, bus.s};
  assign fill_inc = (fill == FILL_W'(LEN)) ? fill : fill + FILL_W'(1);
  assign cmp_en   = accept && (fill_inc == FILL_W'(LEN));

  always_comb begin
    hist_d = hist;
    fill_d = fill;
    if (cfg_hit) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      if (!bus.overlap && (|match)) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = nxt[LEN-2:0];
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      hist    <= '0;
      fill    <= '0;
      armed_q <= 1'b0;
    end else begin
      hist    <= hist_d;
      fill    <= fill_d;
      armed_q <= (fill_d == FILL_W'(LEN));
    end
  end

  for (genvar i = 0; i < NPAT; i++) begin : g_chan
    seq_det_chan #(
      .LEN     (LEN),
      .CNT_W   (CNT_W),
      .RST_VAL (RST_PAT[i*LEN +: LEN])
    ) u_chan (
      .ck      (ck),
      .rs      (rs),
      .pat_we  (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))),
      .pat_in  (bus.cfg_pat),
      .cmp_en  (cmp_en),
      .nxt     (nxt),
      .cnt_clr (bus.cnt_clr),
      .match   (match[i]),
      .y       (y_w[i]),
      .cnt     (cnt_w[i*CNT_W +: CNT_W])
    );
  end

  assign bus.y     = y_w;
  assign bus.cnt   = cnt_w;
  assign bus.armed = armed_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Table-driven bench for seq_detect_param (LEN=3, NPAT=2, CNT_W=2) with a scoreboard queue.
module tb_seq_detect_param;

  logic ck;
  logic rs;
  int   checks;
  int   errors;
  int   vid;

  seq_detect_param_if #(.LEN(3), .NPAT(2), .CNT_W(2)) bus ();

  seq_detect_param #(.LEN(3), .NPAT(2), .CNT_W(2), .RST_PAT({3'b100, 3'b011})) dut (
    .ck  (ck),
    .rs  (rs),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic       en, s, ov, we;
    logic [2:0] idx, pat;
    logic       clr;
    logic [1:0] y;
    logic [3:0] cnt;
    logic       armed;
  } vec_t;

  typedef struct {
    logic [1:0] y;
    logic [3:0] cnt;
    logic       armed;
    int         id;
  } exp_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  exp_t sb[$];

  function automatic vec_t v(logic en, logic s, logic ov, logic we, logic [2:0] idx,
                             logic [2:0] pat, logic clr, logic [1:0] y, logic [3:0] cnt,
                             logic armed);
    vec_t r;
    r.en = en; r.s = s; r.ov = ov; r.we = we; r.idx = idx; r.pat = pat; r.clr = clr;
    r.y = y; r.cnt = cnt; r.armed = armed;
    return r;
  endfunction

  task automatic chk(input string nm, input int id, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step%0d got %0h want %0h", nm, id, got, want);
    end
  endtask

  task automatic run_vec(input vec_t t);
    exp_t e;
    @(negedge ck);
    bus.en = t.en; bus.s = t.s; bus.overlap = t.ov; bus.cfg_we = t.we;
    bus.cfg_idx = t.idx; bus.cfg_pat = t.pat; bus.cnt_clr = t.clr;
    sb.push_back('{y: t.y, cnt: t.cnt, armed: t.armed, id: vid});
    vid++;
    @(posedge ck);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", vid, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk("y", e.id, 8'(bus.y), 8'(e.y));
      chk("cnt", e.id, 8'(bus.cnt), 8'(e.cnt));
      chk("armed", e.id, 8'(bus.armed), 8'(e.armed));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; vid = 0;
    rs = 1'b0;
    bus.en = 0; bus.s = 0; bus.overlap = 1; bus.cfg_we = 0;
    bus.cfg_idx = 0; bus.cfg_pat = 0; bus.cnt_clr = 0;

    // Default patterns, overlapping: 0,1,1,0,0
    tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b01,4'b0001,1));
    tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,4'b0001,1));
    tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b10,4'b0101,1));
    tbl_a.push_back(v(0,0,1,0,0,3'b000,1, 2'b00,4'b0000,1));
    // Pattern 0 = 101, overlapping
    tbl_a.push_back(v(0,0,1,1,0,3'b101,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b01,4'b0001,1));
    tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,4'b0001,1));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b01,4'b0010,1));
    // Same stream, non-overlapping
    tbl_a.push_back(v(0,0,1,1,0,3'b101,1, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,0,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,0,0,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,0,0,0,3'b000,0, 2'b01,4'b0001,0));
    tbl_a.push_back(v(1,0,0,0,0,3'b000,0, 2'b00,4'b0001,0));
    tbl_a.push_back(v(1,1,0,0,0,3'b000,0, 2'b00,4'b0001,0));
    // Out-of-range index: no write, bit still dropped
    tbl_a.push_back(v(1,1,0,1,2,3'b111,0, 2'b00,4'b0001,0));
    tbl_a.push_back(v(1,0,0,0,0,3'b000,0, 2'b00,4'b0001,1));
    tbl_a.push_back(v(1,1,0,0,0,3'b000,0, 2'b01,4'b0010,0));
    // Mid-stream write of pattern 1 = 111
    tbl_a.push_back(v(0,0,1,1,0,3'b011,1, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,1,1,3'b111,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b10,4'b0100,1));
    // Saturation: five 011 matches, then a sixth together with cnt_clr
    tbl_a.push_back(v(0,0,1,0,0,3'b000,1, 2'b00,4'b0000,1));
    for (int k = 1; k <= 5; k++) begin
      logic [3:0] prev;
      logic [3:0] cur;
      prev = 4'((k - 1 > 3) ? 3 : k - 1);
      cur  = 4'((k > 3) ? 3 : k);
      tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,prev,1));
      tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,prev,1));
      tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b01,cur,1));
    end
    tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,4'b0011,1));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0011,1));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,1, 2'b01,4'b0000,1));
    // en gaps inside a match
    tbl_a.push_back(v(0,0,1,1,0,3'b011,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    for (int k = 0; k < 4; k++)
      tbl_a.push_back(v(0,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b01,4'b0001,1));
    // Bits 0,1 before the asynchronous reset
    tbl_a.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,4'b0001,1));
    tbl_a.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0001,1));
    // After reset: lone 1 must not complete 011; then 1,0,0 hits restored 100
    tbl_b.push_back(v(1,1,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_b.push_back(v(1,0,1,0,0,3'b000,0, 2'b00,4'b0000,0));
    tbl_b.push_back(v(1,0,1,0,0,3'b000,0, 2'b10,4'b0100,1));

    repeat (2) @(negedge ck);
    chk("rst_y", -1, 8'(bus.y), 8'd0);
    chk("rst_cnt", -1, 8'(bus.cnt), 8'd0);
    chk("rst_armed", -1, 8'(bus.armed), 8'd0);
    rs = 1'b1;

    foreach (tbl_a[i]) run_vec(tbl_a[i]);

    #2;
    rs = 1'b0;
    #1;
    chk("arst_y", vid, 8'(bus.y), 8'd0);
    chk("arst_cnt", vid, 8'(bus.cnt), 8'd0);
    chk("arst_armed", vid, 8'(bus.armed), 8'd0);
    @(negedge ck);
    bus.en = 0;
    rs = 1'b1;

    foreach (tbl_b[i]) run_vec(tbl_b[i]);

    if (sb.size() != 0) chk("scoreboard_leftover", vid, 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
